// File: rtl/pwm_spi_sequencer.sv
// SPI master for the PWM peripheral config port: queues register read/write
// commands and shifts each out as a 16-bit mode-0 frame, strobing a response.
//
// state | meaning
// IDLE  | cs_n high; pop next command when the FIFO is non-empty
// LEAD  | cs_n low for one cycle, bit 15 on sdo before the first sclk rise
// SHIFT | 16 sclk periods; sample sdi on rise, advance sdo on fall
// TRAIL | cs_n low, sclk low for one cycle after the last bit
// GAP   | cs_n high for GAP cycles; response strobe on the first one
module pwm_spi_sequencer #(
    parameter int CLK_DIV    = 2,
    parameter int GAP        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [5:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       sdo,
    input  logic       sdi
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TRAIL = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [2:0]       state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       bit_cnt;
    logic [14:0]      shreg;
    logic [7:0]       rx_sh;
    logic             cur_write;

    logic [14:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt, fifo_cnt_nxt;
    logic             push, pop;
    logic [14:0]      head;
    logic [15:0]      head_frame;
    logic             div_tc, gap_tc, bit_tc;

    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == S_IDLE) && (fifo_cnt != '0);
    assign head       = fifo_mem[rd_ptr];
    assign head_frame = {head[14], 1'b0, head[13:8], head[14] ? head[7:0] : 8'h00};
    assign div_tc     = (div_cnt == '0);
    assign gap_tc     = (gap_cnt == '0);
    assign bit_tc     = (bit_cnt == 4'd0);

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (push && !pop)
            fifo_cnt_nxt = fifo_cnt + CNT_W'(1);
        else if (pop && !push)
            fifo_cnt_nxt = fifo_cnt - CNT_W'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pop) state_nxt = S_LEAD;
            S_LEAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (div_tc && sclk && bit_tc) state_nxt = S_TRAIL;
            S_TRAIL: state_nxt = S_GAP;
            S_GAP:   if (gap_tc) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Storage needs no reset: entries are only read behind the count.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= 4'd0;
            shreg     <= '0;
            rx_sh     <= 8'h00;
            cur_write <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            cs_n      <= 1'b1;
            sclk      <= 1'b0;
            sdo       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state     <= state_nxt;
            fifo_cnt  <= fifo_cnt_nxt;
            cmd_ready <= (fifo_cnt_nxt != CNT_FULL);
            busy      <= (fifo_cnt_nxt != '0) || (state_nxt != S_IDLE);
            rsp_valid <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg     <= head_frame[14:0];
                        cur_write <= head[14];
                        cs_n      <= 1'b0;
                        sclk      <= 1'b0;
                        sdo       <= head_frame[15];
                    end
                end
                S_LEAD: begin
                    div_cnt <= DIV_LOAD;
                    bit_cnt <= 4'd15;
                end
                S_SHIFT: begin
                    if (!div_tc) begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end else if (!sclk) begin
                        sclk    <= 1'b1;
                        rx_sh   <= {rx_sh[6:0], sdi};
                        div_cnt <= DIV_LOAD;
                    end else begin
                        // Falling sclk: next bit out, or leave for TRAIL after bit 0.
                        sclk <= 1'b0;
                        if (!bit_tc) begin
                            bit_cnt <= bit_cnt - 4'd1;
                            shreg   <= {shreg[13:0], 1'b0};
                            sdo     <= shreg[14];
                            div_cnt <= DIV_LOAD;
                        end
                    end
                end
                S_TRAIL: begin
                    cs_n      <= 1'b1;
                    sdo       <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= cur_write ? 8'h00 : rx_sh;
                    gap_cnt   <= GAP_LOAD;
                end
                S_GAP: begin
                    if (!gap_tc)
                        gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_spi_sequencer.sv
// Bench for pwm_spi_sequencer: two instances (default timing and the fastest
// CLK_DIV=1/GAP=1 setting), a bus monitor/slave, and a queue-based frame model.
module tb_pwm_spi_sequencer;
    localparam int DIV0  = 2;
    localparam int GAP0  = 2;
    localparam int DIV1  = 1;
    localparam int GAP1  = 1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       [2];
    logic       cmd_valid [2];
    logic       cmd_write [2];
    logic [5:0] cmd_addr  [2];
    logic [7:0] cmd_wdata [2];
    logic       sdi       [2] = '{1'b0, 1'b0};
    logic       cmd_ready [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic       busy      [2];
    logic       sclk      [2];
    logic       cs_n      [2];
    logic       sdo       [2];

    pwm_spi_sequencer #(.CLK_DIV(DIV0), .GAP(GAP0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .sclk(sclk[0]), .cs_n(cs_n[0]), .sdo(sdo[0]), .sdi(sdi[0])
    );

    pwm_spi_sequencer #(.CLK_DIV(DIV1), .GAP(GAP1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .sclk(sclk[1]), .cs_n(cs_n[1]), .sdo(sdo[1]), .sdi(sdi[1])
    );

    int checks = 0;
    int errors = 0;
    int div_of [2] = '{DIV0, DIV1};
    int gap_of [2] = '{GAP0, GAP1};

    // Reference model: what each accepted command must look like on the wire.
    logic [15:0] exp_fr  [$];
    logic [7:0]  exp_rsp [$];
    logic [7:0]  slave_tab [2][64];
    int          clr_cnt [2] = '{0, 0};

    // Monitor log, owned by the monitor process only.
    int          cyc = 0;
    int          clr_seen [2] = '{0, 0};
    logic        cs_prev [2] = '{1'b1, 1'b1};
    logic        sclk_prev [2] = '{1'b0, 1'b0};
    logic        busy_prev [2] = '{1'b0, 1'b0};
    int          lo_cnt [2] = '{0, 0};
    int          hi_cnt [2] = '{0, 0};
    int          rises [2] = '{0, 0};
    logic [15:0] bits [2];
    int          fr_n [2] = '{0, 0};
    int          fr_s [2] = '{0, 0};
    int          rsp_n [2] = '{0, 0};
    int          busy_fall [2] = '{0, 0};
    logic [15:0] fr_data [2][64];
    int          fr_low [2][64];
    int          fr_gap [2][64];
    int          fr_rises [2][64];
    int          fr_start [2][64];
    logic [7:0]  rsp_d [2][64];
    logic        rsp_ok [2][64];
    int          rsp_cyc [2][64];

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (clr_seen[d] != clr_cnt[d]) begin
                clr_seen[d]  = clr_cnt[d];
                fr_n[d]      = 0;
                fr_s[d]      = 0;
                rsp_n[d]     = 0;
                busy_fall[d] = 0;
            end
            if (!cs_n[d]) begin
                if (cs_prev[d]) begin
                    if (fr_s[d] < 64) begin
                        fr_gap[d][fr_s[d]]   = hi_cnt[d];
                        fr_start[d][fr_s[d]] = cyc;
                    end
                    fr_s[d]++;
                    lo_cnt[d] = 0;
                    rises[d]  = 0;
                    bits[d]   = 16'h0000;
                end
                lo_cnt[d]++;
                if (sclk[d] && !sclk_prev[d]) begin
                    bits[d] = {bits[d][14:0], sdo[d]};
                    rises[d]++;
                end
                // Slave: present the response byte during the data byte, noise before it.
                if (!sclk[d]) begin
                    if (rises[d] >= 8 && rises[d] < 16 && fr_s[d] >= 1 && fr_s[d] <= 64)
                        sdi[d] = slave_tab[d][fr_s[d]-1][15-rises[d]];
                    else
                        sdi[d] = 1'($urandom_range(0, 1));
                end
            end else begin
                if (!cs_prev[d]) begin
                    if (fr_n[d] < 64) begin
                        fr_data[d][fr_n[d]]  = bits[d];
                        fr_low[d][fr_n[d]]   = lo_cnt[d];
                        fr_rises[d][fr_n[d]] = rises[d];
                    end
                    fr_n[d]++;
                    hi_cnt[d] = 0;
                end
                hi_cnt[d]++;
            end
            if (rsp_valid[d]) begin
                if (rsp_n[d] < 64) begin
                    rsp_d[d][rsp_n[d]]   = rsp_rdata[d];
                    rsp_ok[d][rsp_n[d]]  = cs_n[d] && !cs_prev[d];
                    rsp_cyc[d][rsp_n[d]] = cyc;
                end
                rsp_n[d]++;
            end
            if (busy_prev[d] && !busy[d])
                busy_fall[d] = cyc;
            cs_prev[d]   = cs_n[d];
            sclk_prev[d] = sclk[d];
            busy_prev[d] = busy[d];
        end
    end

    task automatic clear_log(input int d);
        clr_cnt[d]++;
        exp_fr.delete();
        exp_rsp.delete();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int d, input logic w, input logic [5:0] a, input logic [7:0] v,
                        output int pcyc);
        int n = 0;
        cmd_valid[d] = 1'b1;
        cmd_write[d] = w;
        cmd_addr[d]  = a;
        cmd_wdata[d] = v;
        while (!cmd_ready[d] && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (cmd_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL push_accept d=%0d cmd_ready=%0b required 1 within 500 cycles", d, cmd_ready[d]);
        end
        @(posedge clk);
        #2;
        pcyc = cyc;
        cmd_valid[d] = 1'b0;
        exp_fr.push_back({w, 1'b0, a, w ? v : 8'h00});
        exp_rsp.push_back(w ? 8'h00 : slave_tab[d][exp_fr.size()-1]);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while ((busy[d] || !cs_n[d]) && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (busy[d] !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout d=%0d busy=%0b required 0", d, busy[d]);
        end
    endtask

    task automatic test_reset();
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++; if (cs_n[d] !== 1'b1) begin errors++; $display("FAIL reset_cs_n d=%0d got %b exp 1", d, cs_n[d]); end
            checks++; if (sclk[d] !== 1'b0) begin errors++; $display("FAIL reset_sclk d=%0d got %b exp 0", d, sclk[d]); end
            checks++; if (sdo[d] !== 1'b0) begin errors++; $display("FAIL reset_sdo d=%0d got %b exp 0", d, sdo[d]); end
            checks++; if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid d=%0d got %b exp 0", d, rsp_valid[d]); end
            checks++; if (rsp_rdata[d] !== 8'h00) begin errors++; $display("FAIL reset_rsp_rdata d=%0d got %h exp 00", d, rsp_rdata[d]); end
            checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy d=%0d got %b exp 0", d, busy[d]); end
            checks++; if (cmd_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready d=%0d got %b exp 1", d, cmd_ready[d]); end
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        clear_log(1);
        clear_log(0);
    endtask

    task automatic test_single_write();
        int pc;
        clear_log(0);
        push(0, 1'b1, 6'h02, 8'hA5, pc);
        wait_idle(0);
        checks++; if (fr_n[0] != 1) begin errors++; $display("FAIL wr_frame_count got %0d exp 1", fr_n[0]); end
        checks++; if (fr_data[0][0] !== 16'h82A5) begin errors++; $display("FAIL wr_sdo_bits got %h exp 82a5", fr_data[0][0]); end
        checks++; if (fr_rises[0][0] != 16) begin errors++; $display("FAIL wr_sclk_pulses got %0d exp 16", fr_rises[0][0]); end
        checks++; if (fr_low[0][0] != 2 + 32*DIV0) begin errors++; $display("FAIL wr_cs_low got %0d exp %0d", fr_low[0][0], 2 + 32*DIV0); end
        checks++; if (fr_start[0][0] - pc + 1 != 2) begin errors++; $display("FAIL wr_push_to_cs got %0d exp 2", fr_start[0][0] - pc + 1); end
        checks++; if (rsp_n[0] != 1) begin errors++; $display("FAIL wr_rsp_count got %0d exp 1", rsp_n[0]); end
        checks++; if (rsp_d[0][0] !== 8'h00) begin errors++; $display("FAIL wr_rsp_rdata got %h exp 00", rsp_d[0][0]); end
        checks++; if (rsp_ok[0][0] !== 1'b1) begin errors++; $display("FAIL wr_rsp_timing got %b exp 1", rsp_ok[0][0]); end
    endtask

    task automatic test_read();
        int pc;
        clear_log(0);
        slave_tab[0][0] = 8'h3C;
        push(0, 1'b0, 6'h01, 8'($urandom), pc);
        wait_idle(0);
        checks++; if (fr_data[0][0] !== 16'h0100) begin errors++; $display("FAIL rd_sdo_bits got %h exp 0100", fr_data[0][0]); end
        checks++; if (rsp_n[0] != 1) begin errors++; $display("FAIL rd_rsp_count got %0d exp 1", rsp_n[0]); end
        checks++; if (rsp_d[0][0] !== 8'h3C) begin errors++; $display("FAIL rd_rsp_rdata got %h exp 3c", rsp_d[0][0]); end
        checks++; if (rsp_rdata[0] !== 8'h3C) begin errors++; $display("FAIL rd_rsp_hold got %h exp 3c", rsp_rdata[0]); end
    endtask

    task automatic test_back_to_back();
        int pc;
        int n = 0;
        clear_log(0);
        for (int i = 0; i < 6; i++) slave_tab[0][i] = 8'($urandom);
        push(0, 1'($urandom), 6'($urandom), 8'($urandom), pc);
        while (cs_n[0] && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        for (int i = 0; i < 4; i++) push(0, 1'($urandom), 6'($urandom), 8'($urandom), pc);
        checks++; if (cmd_ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b exp 0", cmd_ready[0]); end
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy[0]); end
        push(0, 1'($urandom), 6'($urandom), 8'($urandom), pc);
        checks++; if (pc != rsp_cyc[0][0] + GAP0 + 2) begin errors++; $display("FAIL b2b_fifth_accept got cycle %0d exp %0d", pc, rsp_cyc[0][0] + GAP0 + 2); end
        wait_idle(0);
        checks++; if (fr_n[0] != exp_fr.size()) begin errors++; $display("FAIL b2b_frame_count got %0d exp %0d", fr_n[0], exp_fr.size()); end
        for (int i = 0; i < exp_fr.size(); i++) begin
            checks++; if (fr_data[0][i] !== exp_fr[i]) begin errors++; $display("FAIL b2b_frame[%0d] got %h exp %h", i, fr_data[0][i], exp_fr[i]); end
            checks++; if (rsp_d[0][i] !== exp_rsp[i]) begin errors++; $display("FAIL b2b_rsp[%0d] got %h exp %h", i, rsp_d[0][i], exp_rsp[i]); end
            checks++; if (fr_low[0][i] != 2 + 32*DIV0) begin errors++; $display("FAIL b2b_cs_low[%0d] got %0d exp %0d", i, fr_low[0][i], 2 + 32*DIV0); end
            if (i > 0) begin
                checks++; if (fr_gap[0][i] != GAP0 + 1) begin errors++; $display("FAIL b2b_gap[%0d] got %0d exp %0d", i, fr_gap[0][i], GAP0 + 1); end
            end
        end
        checks++; if (busy_fall[0] - rsp_cyc[0][5] != GAP0) begin errors++; $display("FAIL b2b_busy_fall got %0d exp %0d", busy_fall[0] - rsp_cyc[0][5], GAP0); end
    endtask

    task automatic test_random();
        int pc;
        clear_log(0);
        for (int i = 0; i < 10; i++) slave_tab[0][i] = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            push(0, 1'($urandom), 6'($urandom), 8'($urandom), pc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
        end
        wait_idle(0);
        checks++; if (fr_n[0] != exp_fr.size()) begin errors++; $display("FAIL rnd_frame_count got %0d exp %0d", fr_n[0], exp_fr.size()); end
        checks++; if (rsp_n[0] != exp_rsp.size()) begin errors++; $display("FAIL rnd_rsp_count got %0d exp %0d", rsp_n[0], exp_rsp.size()); end
        for (int i = 0; i < exp_fr.size(); i++) begin
            checks++; if (fr_data[0][i] !== exp_fr[i]) begin errors++; $display("FAIL rnd_frame[%0d] got %h exp %h", i, fr_data[0][i], exp_fr[i]); end
            checks++; if (rsp_d[0][i] !== exp_rsp[i]) begin errors++; $display("FAIL rnd_rsp[%0d] got %h exp %h", i, rsp_d[0][i], exp_rsp[i]); end
            checks++; if (fr_gap[0][i] < GAP0 + 1) begin errors++; $display("FAIL rnd_gap[%0d] got %0d exp >= %0d", i, fr_gap[0][i], GAP0 + 1); end
        end
    endtask

    task automatic test_mid_reset();
        int pc;
        int n = 0;
        clear_log(0);
        for (int i = 0; i < 3; i++) push(0, 1'($urandom), 6'($urandom), 8'($urandom), pc);
        while (!(rises[0] >= 8 && !cs_n[0]) && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        rst[0] = 1'b1;
        @(posedge clk);
        #2;
        checks++; if (cs_n[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_cs_n got %b exp 1", cs_n[0]); end
        checks++; if (sclk[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_sclk got %b exp 0", sclk[0]); end
        checks++; if (sdo[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_sdo got %b exp 0", sdo[0]); end
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp_valid got %b exp 0", rsp_valid[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy[0]); end
        checks++; if (cmd_ready[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_cmd_ready got %b exp 1", cmd_ready[0]); end
        rst[0] = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        checks++; if (fr_s[0] != 1) begin errors++; $display("FAIL mid_rst_frames_started got %0d exp 1", fr_s[0]); end
        checks++; if (rsp_n[0] != 0) begin errors++; $display("FAIL mid_rst_rsp_count got %0d exp 0", rsp_n[0]); end
        checks++; if (fr_rises[0][0] >= 16) begin errors++; $display("FAIL mid_rst_truncated got %0d rises exp < 16", fr_rises[0][0]); end
    endtask

    task automatic test_clkdiv1();
        int pc;
        clear_log(1);
        slave_tab[1][1] = 8'($urandom);
        push(1, 1'b1, 6'h3F, 8'hFF, pc);
        push(1, 1'b0, 6'($urandom), 8'($urandom), pc);
        wait_idle(1);
        checks++; if (fr_n[1] != 2) begin errors++; $display("FAIL div1_frame_count got %0d exp 2", fr_n[1]); end
        checks++; if (fr_data[1][0] !== 16'hBFFF) begin errors++; $display("FAIL div1_sdo_bits got %h exp bfff", fr_data[1][0]); end
        checks++; if (fr_low[1][0] != 2 + 32*DIV1) begin errors++; $display("FAIL div1_cs_low got %0d exp %0d", fr_low[1][0], 2 + 32*DIV1); end
        checks++; if (fr_rises[1][0] != 16) begin errors++; $display("FAIL div1_sclk_pulses got %0d exp 16", fr_rises[1][0]); end
        checks++; if (fr_data[1][1] !== exp_fr[1]) begin errors++; $display("FAIL div1_frame1 got %h exp %h", fr_data[1][1], exp_fr[1]); end
        checks++; if (fr_gap[1][1] != GAP1 + 1) begin errors++; $display("FAIL div1_gap got %0d exp %0d", fr_gap[1][1], GAP1 + 1); end
        checks++; if (rsp_d[1][0] !== exp_rsp[0]) begin errors++; $display("FAIL div1_rsp0 got %h exp %h", rsp_d[1][0], exp_rsp[0]); end
        checks++; if (rsp_d[1][1] !== exp_rsp[1]) begin errors++; $display("FAIL div1_rsp1 got %h exp %h", rsp_d[1][1], exp_rsp[1]); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            cmd_valid[d] = 1'b0;
            cmd_write[d] = 1'b0;
            cmd_addr[d]  = 6'h00;
            cmd_wdata[d] = 8'h00;
        end
        test_reset();
        test_single_write();
        test_read();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_clkdiv1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
